// File: rtl/demux_pkg.sv
// Shared types and default widths for the 1:2 stream demultiplexer.
package demux_pkg;

    localparam int unsigned DEMUX_N     = 32;
    localparam int unsigned DEMUX_CNT_W = 16;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_ONE   = 2'd1,
        SLOT_FULL  = 2'd2
    } slot_state_e;

endpackage

// File: rtl/demux_skid_slot.sv
// Two-entry skid slot: head register drives the output, skid register absorbs
// the beat accepted while the head is stalled.
module demux_skid_slot
    import demux_pkg::*;
#(
    parameter int unsigned N = DEMUX_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [N-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         valid,
    output logic [N-1:0] dout
);

    slot_state_e  state_q, state_d;
    logic [N-1:0] head_q, head_d;
    logic [N-1:0] skid_q, skid_d;
    logic         valid_q, full_q;

    // Next-state and data movement; push never arrives while FULL.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (push) begin
                    state_d = SLOT_ONE;
                    head_d  = din;
                end
            end
            SLOT_ONE: begin
                if (push && pop) begin
                    head_d = din;
                end else if (push) begin
                    state_d = SLOT_FULL;
                    skid_d  = din;
                end else if (pop) begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (pop) begin
                    state_d = SLOT_ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            valid_q <= (state_d != SLOT_EMPTY);
            full_q  <= (state_d == SLOT_FULL);
        end
    end

    assign valid = valid_q;
    assign full  = full_q;
    assign dout  = head_q;

endmodule

// File: rtl/stream_demux_1to2.sv
// 1:2 valid/ready stream demultiplexer with a skid slot per output.
// Optional per-port delivered-beat counters under DEMUX_CNT_EN.
module stream_demux_1to2
    import demux_pkg::*;
#(
    parameter int unsigned N = DEMUX_N
`ifdef DEMUX_CNT_EN
    ,
    parameter int unsigned CNT_W = DEMUX_CNT_W
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_sel,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic [N-1:0] out1_data,
    output logic         out2_valid,
    input  logic         out2_ready,
    output logic [N-1:0] out2_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
`endif
);

    logic full0, full1;
    logic push0, push1;
    logic pop0, pop1;

    // Ready comes only from slot state, never from the consumer readies.
    assign in_ready = in_sel ? !full1 : !full0;
    assign push0    = in_valid && in_ready && !in_sel;
    assign push1    = in_valid && in_ready && in_sel;
    assign pop0     = out1_valid && out1_ready;
    assign pop1     = out2_valid && out2_ready;

    demux_skid_slot #(.N(N)) u_slot0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .din   (in_data),
        .pop   (pop0),
        .full  (full0),
        .valid (out1_valid),
        .dout  (out1_data)
    );

    demux_skid_slot #(.N(N)) u_slot1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .din   (in_data),
        .pop   (pop1),
        .full  (full1),
        .valid (out2_valid),
        .dout  (out2_data)
    );

`ifdef DEMUX_CNT_EN
    // Delivered-beat counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (pop0) cnt1 <= cnt1 + CNT_W'(1);
            if (pop1) cnt2 <= cnt2 + CNT_W'(1);
        end
    end
`endif

endmodule
